// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard unit: forwarding-select
// encodings, the in-flight write entry, and the Tnew ageing helper.
package hazard_pkg;

   // Default index and timing widths of the 5-stage MIPS pipeline.
   localparam int unsigned HZ_REG_W = 5;
   localparam int unsigned HZ_T_W   = 2;

   // Forwarding-mux select encodings shared by the D, E and M muxes.
   localparam logic [1:0] FWD_NONE = 2'd0;
   localparam logic [1:0] FWD_E    = 2'd1;
   localparam logic [1:0] FWD_M    = 2'd2;
   localparam logic [1:0] FWD_W    = 2'd3;

   // Tuse value marking an operand the instruction never reads.
   localparam logic [HZ_T_W-1:0] TUSE_NONE = '1;

   // One GRF write in flight, plus the source indices of the instruction
   // that owns the slot (needed for the E and M stage selects).
   typedef struct packed {
      logic [HZ_REG_W-1:0] dst;
      logic [HZ_T_W-1:0]   tnew;
      logic [HZ_REG_W-1:0] rs;
      logic [HZ_REG_W-1:0] rt;
   } hz_entry_t;

   // Cycles-until-ready shrink by one per stage and stop at zero.
   function automatic logic [HZ_T_W-1:0] tnew_dec(input logic [HZ_T_W-1:0] t);
      return (t == '0) ? '0 : t - HZ_T_W'(1);
   endfunction

endpackage

// File: rtl/hazard_stage.sv
// One pipeline slot of the hazard tracker: holds the entry for the
// instruction currently in that stage, optionally ageing its Tnew.
module hazard_stage
   import hazard_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   input  logic      i_bubble,
   input  logic      i_dec,
   input  hz_entry_t i_d,
   output hz_entry_t o_q
);

   hz_entry_t r_q;
   hz_entry_t w_next;

   // Next entry: either the upstream entry as-is, or with Tnew aged by one.
   always_comb begin
      w_next = i_d;
      if (i_dec) begin
         w_next.tnew = tnew_dec(i_d.tnew);
      end
   end

   // Slot register; reset has priority over the bubble, which has priority over capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_q <= '0;
      end else if (i_bubble) begin
         r_q <= '0;
      end else begin
         r_q <= w_next;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/hazard_unit.sv
// Hazard unit for the 5-stage MIPS pipeline: tracks GRF writes in flight
// from E to W, stalls D on unresolvable read-after-write hazards and drives
// the forwarding selects at D, E and M.
module hazard_unit
   import hazard_pkg::*;
#(
   parameter int unsigned REG_W = HZ_REG_W,
   parameter int unsigned T_W   = HZ_T_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] rs_d,
   input  logic [REG_W-1:0] rt_d,
   input  logic [T_W-1:0]   tuse_rs,
   input  logic [T_W-1:0]   tuse_rt,
   input  logic [REG_W-1:0] dst_d,
   input  logic [T_W-1:0]   tnew_d,
   output logic             stall,
   output logic [1:0]       fwd_rs_d,
   output logic [1:0]       fwd_rt_d,
   output logic [1:0]       fwd_rs_e,
   output logic [1:0]       fwd_rt_e,
   output logic [1:0]       fwd_rt_m
);

   hz_entry_t w_d;
   hz_entry_t w_e;
   hz_entry_t w_m;
   hz_entry_t w_w;

   logic w_stall_rs;
   logic w_stall_rt;
   logic w_unused;

   // A D-stage operand must wait if a producer in E or M will not have its
   // result ready by the time the operand is consumed.
   function automatic logic hazard(
      input logic [REG_W-1:0] r,
      input logic [T_W-1:0]   tuse,
      input hz_entry_t        e,
      input hz_entry_t        m
   );
      logic w_hit_e;
      logic w_hit_m;
      w_hit_e = (e.dst == r) && (e.tnew > tuse);
      w_hit_m = (m.dst == r) && (m.tnew > tuse);
      return (r != '0) && (tuse != TUSE_NONE) && (w_hit_e || w_hit_m);
   endfunction

   // D select: the youngest matching producer decides; a not-yet-ready
   // younger match hides any older one (the operand is picked up later at E).
   function automatic logic [1:0] sel_d(
      input logic [REG_W-1:0] r,
      input hz_entry_t        e,
      input hz_entry_t        m
   );
      logic [1:0] w_sel;
      w_sel = FWD_NONE;
      if (r != '0) begin
         if (e.dst == r) begin
            w_sel = (e.tnew == '0) ? FWD_E : FWD_NONE;
         end else if (m.dst == r) begin
            w_sel = (m.tnew == '0) ? FWD_M : FWD_NONE;
         end
      end
      return w_sel;
   endfunction

   // E select: M is the youngest producer ahead of E; W results are always ready.
   function automatic logic [1:0] sel_e(
      input logic [REG_W-1:0] r,
      input hz_entry_t        m,
      input hz_entry_t        w
   );
      logic [1:0] w_sel;
      w_sel = FWD_NONE;
      if (r != '0) begin
         if (m.dst == r) begin
            w_sel = (m.tnew == '0) ? FWD_M : FWD_NONE;
         end else if (w.dst == r) begin
            w_sel = FWD_W;
         end
      end
      return w_sel;
   endfunction

   assign w_d = '{dst: dst_d, tnew: tnew_d, rs: rs_d, rt: rt_d};

   hazard_stage u_stage_e (
      .clk      (clk),
      .reset    (reset),
      .i_bubble (stall),
      .i_dec    (1'b0),
      .i_d      (w_d),
      .o_q      (w_e)
   );

   hazard_stage u_stage_m (
      .clk      (clk),
      .reset    (reset),
      .i_bubble (1'b0),
      .i_dec    (1'b1),
      .i_d      (w_e),
      .o_q      (w_m)
   );

   hazard_stage u_stage_w (
      .clk      (clk),
      .reset    (reset),
      .i_bubble (1'b0),
      .i_dec    (1'b1),
      .i_d      (w_m),
      .o_q      (w_w)
   );

   // Stall and forwarding selects, combinational on the D inputs and entries.
   always_comb begin
      w_stall_rs = hazard(rs_d, tuse_rs, w_e, w_m);
      w_stall_rt = hazard(rt_d, tuse_rt, w_e, w_m);
      stall      = w_stall_rs || w_stall_rt;
      fwd_rs_d   = sel_d(rs_d, w_e, w_m);
      fwd_rt_d   = sel_d(rt_d, w_e, w_m);
      fwd_rs_e   = sel_e(w_e.rs, w_m, w_w);
      fwd_rt_e   = sel_e(w_e.rt, w_m, w_w);
      fwd_rt_m   = ((w_m.rt != '0) && (w_w.dst == w_m.rt)) ? FWD_W : FWD_NONE;
   end

   // Fields carried for uniformity but never consulted downstream.
   assign w_unused = ^{w_w.tnew, w_w.rs, w_w.rt, w_m.rs};

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: a stimulus process drives D-stage
// instructions and pushes the reference model's expected outputs; a monitor
// pops and compares them mid-cycle.
module tb_hazard_unit;

   localparam logic [1:0] FN = 2'd0;
   localparam logic [1:0] FE = 2'd1;
   localparam logic [1:0] FM = 2'd2;
   localparam logic [1:0] FW = 2'd3;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] rs_d, rt_d, dst_d;
   logic [1:0] tuse_rs, tuse_rt, tnew_d;
   logic       stall;
   logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m;

   hazard_unit #(.REG_W(5), .T_W(2)) dut (
      .clk      (clk),
      .reset    (reset),
      .rs_d     (rs_d),
      .rt_d     (rt_d),
      .tuse_rs  (tuse_rs),
      .tuse_rt  (tuse_rt),
      .dst_d    (dst_d),
      .tnew_d   (tnew_d),
      .stall    (stall),
      .fwd_rs_d (fwd_rs_d),
      .fwd_rt_d (fwd_rt_d),
      .fwd_rs_e (fwd_rs_e),
      .fwd_rt_e (fwd_rt_e),
      .fwd_rt_m (fwd_rt_m)
   );

   always #5 clk = ~clk;

   // Reference model: instructions in flight, each tagged with its age
   // (0 = E, 1 = M, 2 = W) and the Tnew it had on entering E.
   typedef struct {
      int dst;
      int t;
      int rs;
      int rt;
      int age;
   } instr_t;

   typedef struct {
      logic [1:0] st;
      logic [1:0] rsd;
      logic [1:0] rtd;
      logic [1:0] rse;
      logic [1:0] rte;
      logic [1:0] rtm;
   } exp_t;

   instr_t flight[$];
   exp_t   sbq[$];
   bit     model_known = 0;
   int     n_checks = 0;
   int     n_pass = 0;

   function automatic int at_age(input int a);
      foreach (flight[i]) if (flight[i].age == a) return i;
      return -1;
   endfunction

   function automatic int t_now(input int i);
      return (flight[i].t > flight[i].age) ? flight[i].t - flight[i].age : 0;
   endfunction

   function automatic bit m_hazard(input int r, input int tu);
      if (r == 0 || tu == 3) return 0;
      foreach (flight[i])
         if (flight[i].age <= 1 && flight[i].dst == r && t_now(i) > tu) return 1;
      return 0;
   endfunction

   function automatic logic [1:0] m_fwd_d(input int r);
      int ie, im;
      if (r == 0) return FN;
      ie = at_age(0);
      im = at_age(1);
      if (ie >= 0) if (flight[ie].dst == r) return (t_now(ie) == 0) ? FE : FN;
      if (im >= 0) if (flight[im].dst == r) return (t_now(im) == 0) ? FM : FN;
      return FN;
   endfunction

   function automatic logic [1:0] m_fwd_e(input bit use_rt);
      int ie, im, iw, r;
      ie = at_age(0);
      if (ie < 0) return FN;
      r = use_rt ? flight[ie].rt : flight[ie].rs;
      if (r == 0) return FN;
      im = at_age(1);
      iw = at_age(2);
      if (im >= 0) if (flight[im].dst == r) return (t_now(im) == 0) ? FM : FN;
      if (iw >= 0) if (flight[iw].dst == r) return FW;
      return FN;
   endfunction

   function automatic logic [1:0] m_fwd_m();
      int im, iw;
      im = at_age(1);
      iw = at_age(2);
      if (im < 0 || iw < 0) return FN;
      if (flight[im].rt != 0 && flight[iw].dst == flight[im].rt) return FW;
      return FN;
   endfunction

   task automatic check(input string nm, input logic [1:0] act, input logic [1:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      else n_pass++;
   endtask

   // One clock of stimulus; returns the model's stall for this cycle.
   task automatic step(input bit rst, input int rs, input int rt, input int tus,
                       input int tut, input int dst, input int tn, output bit st);
      exp_t   x;
      instr_t ni;
      reset   = rst;
      rs_d    = 5'(rs);
      rt_d    = 5'(rt);
      tuse_rs = 2'(tus);
      tuse_rt = 2'(tut);
      dst_d   = 5'(dst);
      tnew_d  = 2'(tn);
      st = 0;
      if (model_known) begin
         st    = m_hazard(rs, tus) || m_hazard(rt, tut);
         x.st  = {1'b0, st};
         x.rsd = m_fwd_d(rs);
         x.rtd = m_fwd_d(rt);
         x.rse = m_fwd_e(0);
         x.rte = m_fwd_e(1);
         x.rtm = m_fwd_m();
         sbq.push_back(x);
      end
      @(posedge clk);
      #1;
      if (rst) begin
         flight.delete();
         model_known = 1;
      end else if (model_known) begin
         foreach (flight[i]) flight[i].age++;
         for (int i = flight.size() - 1; i >= 0; i--)
            if (flight[i].age > 2) flight.delete(i);
         if (!st) begin
            ni = '{dst: dst, t: tn, rs: rs, rt: rt, age: 0};
            flight.push_back(ni);
         end
      end
   endtask

   // Present an instruction at D until it is no longer stalled.
   task automatic issue(input int rs, input int rt, input int tus, input int tut,
                        input int dst, input int tn);
      bit st;
      int guard;
      guard = 0;
      do begin
         step(0, rs, rt, tus, tut, dst, tn, st);
         guard++;
      end while (st && guard < 8);
   endtask

   task automatic nops(input int n);
      for (int i = 0; i < n; i++) issue(0, 0, 3, 3, 0, 0);
   endtask

   // Monitor: compare every expected response once the DUT has settled.
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         if (sbq.size() > 0) begin
            x = sbq.pop_front();
            check("stall",    {1'b0, stall}, x.st);
            check("fwd_rs_d", fwd_rs_d, x.rsd);
            check("fwd_rt_d", fwd_rt_d, x.rtd);
            check("fwd_rs_e", fwd_rs_e, x.rse);
            check("fwd_rt_e", fwd_rt_e, x.rte);
            check("fwd_rt_m", fwd_rt_m, x.rtm);
         end
      end
   end

   initial begin
      bit st;
      bit hold;
      int rs, rt, tus, tut, dst, tn;
      step(1, 0, 0, 3, 3, 0, 0, st);
      step(1, 0, 0, 3, 3, 0, 0, st);

      // load-use: lw $8 ; addu rs=$8
      issue(1, 0, 1, 3, 8, 2);
      issue(8, 0, 1, 3, 11, 1);
      nops(3);
      // ALU result to branch: addu $9 ; beq $9
      issue(2, 3, 1, 1, 9, 1);
      issue(9, 0, 0, 0, 0, 0);
      nops(3);
      // jal ; jr $31
      issue(0, 0, 3, 3, 31, 0);
      issue(31, 0, 0, 3, 0, 0);
      nops(3);
      // lw $10 ; sw rt=$10
      issue(4, 0, 1, 3, 10, 2);
      issue(5, 10, 1, 2, 0, 0);
      nops(3);
      // writes to $0 are never forwarded
      issue(5, 0, 1, 3, 0, 1);
      issue(0, 0, 0, 0, 12, 1);
      nops(3);
      // reset during a load-use stall, then the $8 consumer sees nothing
      issue(1, 0, 1, 3, 8, 2);
      step(0, 8, 0, 1, 3, 11, 1, st);
      step(1, 8, 0, 1, 3, 11, 1, st);
      issue(8, 8, 0, 0, 13, 1);
      nops(3);

      // randomized traffic over a small register set to provoke overlaps
      hold = 0;
      for (int n = 0; n < 800; n++) begin
         if (!hold) begin
            rs  = $urandom_range(0, 3);
            rt  = $urandom_range(0, 3);
            tus = $urandom_range(0, 3);
            tut = $urandom_range(0, 3);
            dst = $urandom_range(0, 3);
            tn  = $urandom_range(0, 2);
         end
         step(($urandom_range(0, 39) == 0), rs, rt, tus, tut, dst, tn, st);
         hold = st;
      end

      nops(2);
      @(negedge clk);
      @(negedge clk);
      check("drain", 2'(sbq.size() != 0), 2'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Tracks every GRF write in flight, from E through W, for the 5-stage MIPS pipeline.
- Resolves the register reads issued at D against those writes.
- Drives the pipeline stall and the forwarding-mux selects at D, E and M.
- Is the producer-side counterpart of the register file, which itself only bypasses a same-cycle W-stage write to D.

Parameters:
REG_W, 5, register-index width
T_W, 2, width of Tuse/Tnew fields

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
rs_d  in  REG_W  D-stage rs index
rt_d  in  REG_W  D-stage rt index
tuse_rs  in  T_W  cycles after D until rs is consumed; 3 = rs unused
tuse_rt  in  T_W  same for rt
dst_d  in  REG_W  D-stage destination register; 0 = no write
tnew_d  in  T_W  cycles after entering E until result ready (link=0, ALU=1, load=2)
stall  out  1  freeze PC and F/D; insert bubble into E
fwd_rs_d  out  2  D rs select
fwd_rt_d  out  2  D rt select
fwd_rs_e  out  2  E rs select
fwd_rt_e  out  2  E rt select
fwd_rt_m  out  2  M store-data select

Behaviour:
- Clock and reset: clk rising edge; reset synchronous, active-high, wins over stall.
- Reset clears all entries to zero, so stall=0 and every fwd_*=FWD_NONE the cycle after reset.
- Select encoding: FWD_NONE=0, FWD_E=1 (D selects only), FWD_M=2, FWD_W=3 (E/M selects only).
- Internal state: three entries E, M, W, each {dst, tnew, rs, rt}.
- Advance when not stalled: E<=captured D {dst_d, tnew_d, rs_d, rt_d}; M<=E with tnew-1 saturating at 0; W<=M with tnew-1 saturating at 0.
- Advance when stalled: E<=bubble (all zero); M and W advance as normal. Upstream holds the D inputs stable.
- Stall term for rs: rs_d!=0, tuse_rs!=3, and either (dst_e==rs_d and tnew_e>tuse_rs) or (dst_m==rs_d and tnew_m>tuse_rs). The rt term is identical.
- stall = rs term OR rt term. It is combinational from the D inputs and registered entries.
- fwd_rs_d, closest producer first:
  - if rs_d==0, FWD_NONE;
  - dst_e==rs_d: FWD_E if tnew_e==0, else FWD_NONE (no fall-through to an older M entry);
  - else dst_m==rs_d: FWD_M if tnew_m==0, else FWD_NONE;
  - else FWD_NONE. The W match is served by the GRF's internal bypass.
- fwd_rt_d: same rule with rt_d.
- fwd_rs_e, using rs from the E entry:
  - if rs_e==0, FWD_NONE;
  - dst_m match: FWD_M if tnew_m==0, else FWD_NONE;
  - else dst_w match: FWD_W;
  - else FWD_NONE.
- fwd_rt_e: same rule with rt_e.
- fwd_rt_m: FWD_W if rt_m!=0 and dst_w==rt_m, else FWD_NONE.
- Register 0: never matches, never causes a stall or forward.
- Bubbles carry dst=0, so they are invisible to all comparisons.
- Simultaneous rs and rt hazards: one stall, no double counting.
- Back-to-back stalls: permitted. Each stalled cycle re-evaluates with the advanced M/W entries.
- Reset mid-stall: the stall drops the cycle after reset, and the pending instruction in D is discarded by the pipeline.
- Latency: selects and stall are combinational on the current entries. Entry update is one cycle.

Decomposition:
- Package hazard_pkg holds:
  - constants FWD_NONE/FWD_E/FWD_M/FWD_W and TUSE_NONE=3;
  - the entry struct {dst, tnew, rs, rt};
  - a function tnew_dec (saturating decrement).
- Sub-module hazard_stage: one entry register, with bubble and decrement controls and synchronous reset, instantiated three times.
- Comparison and select logic lives in the top level.

Test Plan:
- lw $8 (tnew 2) followed by addu using rs=$8 (tuse 1):
  - 1 stall cycle; E=bubble;
  - next cycle stall=0 and fwd_rs_d=FWD_NONE (M tnew 1);
  - following cycle fwd_rs_e=FWD_W.
- addu $9 followed by beq with rs=$9 (tuse 0):
  - 1 stall;
  - next cycle fwd_rs_d=FWD_M, stall=0.
- jal ($31, tnew 0) followed by jr $31 (tuse 0): stall=0, fwd_rs_d=FWD_E.
- lw $10 followed by sw with rt=$10 (tuse_rt 2):
  - no stall;
  - sw in E: fwd_rt_e=FWD_NONE;
  - sw in M: fwd_rt_m=FWD_W.
- Producer with dst=$0 followed by a consumer of $0: stall=0 and all selects FWD_NONE.
- Reset asserted during a load-use stall:
  - next cycle stall=0, all selects FWD_NONE;
  - all entries zero (a subsequent consumer of $8 sees no match).
